store_alloc_ctrl: RTL and testbench

STORE_ALLOC_CTRL -- requirements
Module: store_alloc_ctrl

---
 rtl/store_pkg.sv | 7 +
 rtl/store_alloc_ctrl_if.sv | 30 +++
 rtl/store_ptr_inc.sv | 10 +
 rtl/store_alloc_ctrl.sv | 87 ++++++++
 tb/tb_store_alloc_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store-number allocator: number width, in-flight depth, number type.
// DEPTH must not exceed half the number space so age order stays unambiguous.
package store_pkg;
   localparam int NUM_W = 5;
   localparam int DEPTH = 16;
   typedef logic [NUM_W-1:0] store_num_t;
endpackage

// File: rtl/store_alloc_ctrl_if.sv
// Dispatch/retire/flush bundle between the pipeline front end (master) and the allocator (slave).
// Grants and stall are combinational in the request cycle.
interface store_alloc_ctrl_if #(
   parameter int NUM_W = store_pkg::NUM_W
);
   logic             st_1;
   logic             st_2;
   logic             ret_1;
   logic             ret_2;
   logic             flush;
   logic [NUM_W-1:0] flush_num;
   logic [NUM_W-1:0] store_num_1;
   logic [NUM_W-1:0] store_num_2;
   logic             stall;
   logic [NUM_W-1:0] oldest_num;
   logic [NUM_W-1:0] count;
   logic             empty;
   logic             full;
   logic             err;

   modport master (
      output st_1, st_2, ret_1, ret_2, flush, flush_num,
      input  store_num_1, store_num_2, stall, oldest_num, count, empty, full, err
   );

   modport slave (
      input  st_1, st_2, ret_1, ret_2, flush, flush_num,
      output store_num_1, store_num_2, stall, oldest_num, count, empty, full, err
   );
endinterface

// File: rtl/store_ptr_inc.sv
// Modulo pointer advance by 0, 1 or 2; purely combinational, natural wrap at 2^W.
module store_ptr_inc #(
   parameter int W = store_pkg::NUM_W
) (
   input  logic [W-1:0] ptr,
   input  logic [1:0]   inc,
   output logic [W-1:0] ptr_nxt
);
   assign ptr_nxt = ptr + W'(inc);
endmodule

// File: rtl/store_alloc_ctrl.sv
// Store-number allocator: hands out up to two numbers per cycle, retires in order, rewinds on flush.
// Grants/stall are combinational off registered count (no retire forwarding); state updates next edge.
module store_alloc_ctrl #(
   parameter int NUM_W = store_pkg::NUM_W,
   parameter int DEPTH = store_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   store_alloc_ctrl_if.slave bus
);
   import store_pkg::*;

   typedef logic [NUM_W-1:0] num_t;

   num_t       head_q, tail_q, count_q;
   logic       err_q;
   num_t       head_adv, tail_adv, fl_dist, live_after;
   num_t       tail_d, count_d;
   logic       err_d;
   logic [1:0] n, r_req, r_eff, alloc;
   logic       over_ret, bad_ret, stall_c, fl_ok;

   assign n = {1'b0, bus.st_1} + {1'b0, bus.st_2};

   // A lone ret_2 still retires one entry; it is flagged below as a protocol error.
   always_comb begin
      r_req = 2'd0;
      if (bus.ret_1 && bus.ret_2)
         r_req = 2'd2;
      else if (bus.ret_1 || bus.ret_2)
         r_req = 2'd1;
   end

   assign over_ret = num_t'(r_req) > count_q;
   assign r_eff    = over_ret ? count_q[1:0] : r_req;
   assign bad_ret  = over_ret || (bus.ret_2 && !bus.ret_1);

   assign stall_c = !bus.flush && (num_t'(n) > (num_t'(DEPTH) - count_q));
   assign alloc   = (bus.flush || stall_c) ? 2'd0 : n;

   store_ptr_inc #(.W(NUM_W)) u_head_inc (.ptr(head_q), .inc(r_eff), .ptr_nxt(head_adv));
   store_ptr_inc #(.W(NUM_W)) u_tail_inc (.ptr(tail_q), .inc(alloc), .ptr_nxt(tail_adv));

   // A legal flush point lies between the post-retire head and tail in modulo order.
   assign live_after = count_q - num_t'(r_eff);
   assign fl_dist    = bus.flush_num - head_adv;
   assign fl_ok      = fl_dist <= live_after;

   always_comb begin
      tail_d  = tail_adv;
      count_d = count_q + num_t'(alloc) - num_t'(r_eff);
      err_d   = err_q || bad_ret;
      if (bus.flush) begin
         if (fl_ok) begin
            tail_d  = bus.flush_num;
            count_d = fl_dist;
         end else begin
            tail_d  = tail_q;
            count_d = live_after;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_adv;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.store_num_1 = tail_q;
   assign bus.store_num_2 = tail_q + num_t'(bus.st_1);
   assign bus.stall       = stall_c;
   assign bus.oldest_num  = head_q;
   assign bus.count       = count_q;
   assign bus.empty       = count_q == '0;
   assign bus.full        = count_q == num_t'(DEPTH);
   assign bus.err         = err_q;
endmodule

// File: tb/tb_store_alloc_ctrl.sv
// Directed table plus hand sequences for the store-number allocator.
module tb_store_alloc_ctrl;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   store_alloc_ctrl_if bus ();

   store_alloc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int st1, st2, r1, r2, fl, fnum;
      int sn1, sn2, stl;
      int old, cnt, er;
   } vec_t;

   vec_t vt[7];

   function automatic vec_t mk(input int st1, st2, r1, r2, fl, fnum,
                               input int sn1, sn2, stl, old, cnt, er);
      vec_t v;
      v.st1 = st1; v.st2 = st2; v.r1 = r1; v.r2 = r2; v.fl = fl; v.fnum = fnum;
      v.sn1 = sn1; v.sn2 = sn2; v.stl = stl; v.old = old; v.cnt = cnt; v.er = er;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input int st1, st2, r1, r2, fl, fnum);
      bus.st_1      = (st1 != 0);
      bus.st_2      = (st2 != 0);
      bus.ret_1     = (r1 != 0);
      bus.ret_2     = (r2 != 0);
      bus.flush     = (fl != 0);
      bus.flush_num = 5'(fnum);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int st1, st2, r1, r2, fl, fnum);
      drive(st1, st2, r1, r2, fl, fnum);
      tick();
   endtask

   task automatic chk_comb(input string tag, input int sn1, sn2, stl);
      chk({tag, ".store_num_1"}, int'(bus.store_num_1), sn1);
      chk({tag, ".store_num_2"}, int'(bus.store_num_2), sn2);
      chk({tag, ".stall"}, int'(bus.stall), stl);
   endtask

   task automatic chk_regs(input string tag, input int old, cnt, er);
      chk({tag, ".oldest_num"}, int'(bus.oldest_num), old);
      chk({tag, ".count"}, int'(bus.count), cnt);
      chk({tag, ".empty"}, int'(bus.empty), (cnt == 0) ? 1 : 0);
      chk({tag, ".full"}, int'(bus.full), (cnt == 16) ? 1 : 0);
      chk({tag, ".err"}, int'(bus.err), er);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      //            st1 st2 r1 r2 fl fn | sn1 sn2 stl | old cnt err
      vt[0] = mk(1, 1, 0, 0, 0, 0,   0, 1, 0,   0, 2, 0);
      vt[1] = mk(1, 0, 0, 0, 0, 0,   2, 3, 0,   0, 3, 0);
      vt[2] = mk(0, 1, 0, 0, 0, 0,   3, 3, 0,   0, 4, 0);
      vt[3] = mk(0, 0, 1, 0, 0, 0,   4, 4, 0,   1, 3, 0);
      vt[4] = mk(1, 1, 1, 1, 0, 0,   4, 5, 0,   3, 3, 0);
      vt[5] = mk(1, 0, 0, 0, 1, 5,   6, 7, 0,   3, 2, 0);
      vt[6] = mk(0, 0, 0, 0, 1, 3,   5, 5, 0,   3, 0, 0);

      do_reset();
      chk_comb("reset", 0, 0, 0);
      chk_regs("reset", 0, 0, 0);

      for (int i = 0; i < 7; i++) begin
         drive(vt[i].st1, vt[i].st2, vt[i].r1, vt[i].r2, vt[i].fl, vt[i].fnum);
         chk_comb($sformatf("vec%0d", i), vt[i].sn1, vt[i].sn2, vt[i].stl);
         tick();
         chk_regs($sformatf("vec%0d", i), vt[i].old, vt[i].cnt, vt[i].er);
      end

      // Fill to 15 from head=tail=3, then stall on a double, grant a single to full.
      for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_regs("fill15", 3, 15, 0);
      drive(1, 1, 0, 0, 0, 0);
      chk_comb("dbl_at15", 18, 19, 1);
      tick();
      chk_regs("dbl_at15", 3, 15, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk_comb("sgl_at15", 18, 19, 0);
      tick();
      chk_regs("sgl_at15", 3, 16, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("full_stall", int'(bus.stall), 1);
      drive(1, 1, 0, 0, 1, 19);
      chk("flush_unstall", int'(bus.stall), 0);
      tick();
      chk_regs("flush_at_tail", 3, 16, 0);
      drive(1, 1, 1, 1, 0, 0);
      chk("no_ret_fwd", int'(bus.stall), 1);
      tick();
      chk_regs("no_ret_fwd", 5, 14, 0);

      // Flush combined with retire: head=4, tail=10.
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      chk_regs("pre_flush", 4, 6, 0);
      drive(1, 0, 1, 0, 1, 7);
      chk_comb("flush_ret", 10, 11, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_comb("flush_ret_post", 7, 7, 0);
      chk_regs("flush_ret", 5, 2, 0);

      // Wrap: walk head/tail to 30, then allocate across 31 -> 0.
      do_reset();
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++) step(1, 1, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      chk_regs("at30", 30, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      chk_comb("wrap_a", 30, 31, 0);
      tick();
      drive(1, 1, 0, 0, 0, 0);
      chk_comb("wrap_b", 0, 1, 0);
      tick();
      step(0, 0, 1, 1, 0, 0);
      chk_regs("wrap_ret", 0, 2, 0);

      // Out-of-range flush: head_next=1, tail=2, flush_num=5.
      drive(0, 0, 1, 0, 1, 5);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_comb("bad_flush", 2, 2, 0);
      chk_regs("bad_flush", 1, 1, 1);

      // Over-retire sets a sticky error that only reset clears.
      do_reset();
      chk_regs("rst_clr_err", 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      chk_regs("over_ret", 1, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
      chk_regs("err_sticky", 1, 0, 1);

      // Lone ret_2 retires one entry and flags an error.
      do_reset();
      step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk_regs("lone_ret2", 1, 1, 1);

      // Reset mid-stream at count 9 with busy inputs.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_regs("pre_rst9", 0, 9, 0);
      reset = 1'b0;
      step(1, 1, 1, 1, 0, 0);
      chk_regs("rst_busy", 0, 0, 0);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk_comb("rst_mid", 0, 0, 0);
      chk_regs("rst_mid", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
